// File: rtl/rr_arbiter_mux_pkg.sv
// Shared types and helpers for the round-robin arbiter/mux.
package arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Channel-index width, never below one bit so a single-channel build still has a port.
  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_mux_if.sv
// Valid/ready bundle between NUM_CH sources, the arbiter and one sink.
interface rr_arbiter_mux_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  import arb_pkg::*;

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [CH_W-1:0]          out_ch;
  logic                     out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_ch
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_ch
  );

endinterface

// File: rtl/rr_arbiter_mux_pick.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping modulo NUM_CH.
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_any
);

  localparam logic [CH_W:0] NUM_CH_X = (CH_W+1)'(NUM_CH);

  logic [NUM_CH-1:0] rot_s;
  logic [CH_W-1:0]   off_s;

  // Modulo-NUM_CH add; both operands are already below NUM_CH so one subtract suffices.
  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] a, input logic [CH_W-1:0] b);
    logic [CH_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= NUM_CH_X) ? CH_W'(sum - NUM_CH_X) : sum[CH_W-1:0];
  endfunction

  // Rotate so that the pointer channel lands on bit 0.
  always_comb begin
    rot_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rot_s[i] = req[wrap_add(CH_W'(i), ptr)];
    end
  end

  // Find-first from bit 0, then rotate the offset back to an absolute channel.
  always_comb begin
    off_s   = '0;
    gnt_any = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      off_s   = rot_s[i] ? CH_W'(i) : off_s;
      gnt_any = gnt_any | rot_s[i];
    end
    gnt_idx = wrap_add(off_s, ptr);
  end

endmodule

// File: rtl/rr_arbiter_mux.sv
// Round-robin arbiter merging NUM_CH valid/ready streams into one registered stream,
// optionally holding the grant for a whole packet.
module rr_arbiter_mux
  import arb_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 8,
  parameter int PKT_MODE = 1
) (
  input  logic            clk,
  input  logic            rst,
  rr_arbiter_mux_if.slave bus
);

  localparam int              CH_W    = ch_w(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic            PKT_EN  = (PKT_MODE != 0);

  arb_state_e        state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;

  logic [NUM_CH-1:0] lock_mask_s;
  logic [NUM_CH-1:0] req_s;
  logic [CH_W-1:0]   pick_ptr_s;
  logic [CH_W-1:0]   gnt_idx_s;
  logic [CH_W-1:0]   gnt_next_s;
  logic              gnt_any_s;
  logic              gnt_last_s;
  logic [DATA_W-1:0] gnt_data_s;
  logic              load_s;
  logic              accept_s;

  // While locked only the owning channel may request, so the picker cannot move the grant.
  assign lock_mask_s = NUM_CH'(1) << lock_ch_q;
  assign req_s       = (state_q == ARB_LOCKED) ? (bus.in_valid & lock_mask_s) : bus.in_valid;
  assign pick_ptr_s  = (state_q == ARB_LOCKED) ? lock_ch_q : ptr_q;

  rr_priority_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .req     (req_s),
    .ptr     (pick_ptr_s),
    .gnt_idx (gnt_idx_s),
    .gnt_any (gnt_any_s)
  );

  assign load_s     = !out_valid_q | bus.out_ready;
  assign accept_s   = load_s & gnt_any_s & !rst;
  assign gnt_data_s = bus.in_data[int'(gnt_idx_s) * DATA_W +: DATA_W];
  assign gnt_last_s = bus.in_last[gnt_idx_s];
  assign gnt_next_s = (gnt_idx_s == LAST_CH) ? '0 : gnt_idx_s + CH_W'(1);

  assign bus.in_ready  = accept_s ? (NUM_CH'(1) << gnt_idx_s) : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;

  // Lock FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   state_d = (accept_s && PKT_EN && !gnt_last_s) ? ARB_LOCKED : ARB_IDLE;
      ARB_LOCKED: state_d = (accept_s && gnt_last_s) ? ARB_IDLE : ARB_LOCKED;
      default:    state_d = ARB_IDLE;
    endcase
  end

  // Lock FSM outputs: the pointer only advances on beats that leave the arbiter unlocked,
  // so closing a packet moves it to lock_ch+1.
  always_comb begin
    lock_ch_d = (accept_s && (state_d == ARB_LOCKED)) ? gnt_idx_s : lock_ch_q;
    ptr_d     = (accept_s && (state_d == ARB_IDLE)) ? gnt_next_s : ptr_q;
  end

  // Output register: load on accept, drain when consumed, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data_s;
      out_last_d  = gnt_last_s;
      out_ch_d    = gnt_idx_s;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      lock_ch_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_ch_q   <= lock_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Bench for rr_arbiter_mux: packet-mode and streaming-mode instances share one stimulus,
// each checked against a queue-free round-robin reference model plus directed tables.
module tb_rr_arbiter_mux;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  tb_valid;
  logic [N-1:0]  tb_last;
  logic [N*DW-1:0] tb_data;
  logic          tb_ready;

  always #5 clk = ~clk;

  rr_arbiter_mux_if #(.NUM_CH(N), .DATA_W(DW)) if_p ();
  rr_arbiter_mux_if #(.NUM_CH(N), .DATA_W(DW)) if_s ();

  assign if_p.in_valid  = tb_valid;
  assign if_p.in_last   = tb_last;
  assign if_p.in_data   = tb_data;
  assign if_p.out_ready = tb_ready;
  assign if_s.in_valid  = tb_valid;
  assign if_s.in_last   = tb_last;
  assign if_s.in_data   = tb_data;
  assign if_s.out_ready = tb_ready;

  rr_arbiter_mux #(.NUM_CH(N), .DATA_W(DW), .PKT_MODE(1)) u_dut_pkt (
    .clk (clk),
    .rst (rst),
    .bus (if_p)
  );

  rr_arbiter_mux #(.NUM_CH(N), .DATA_W(DW), .PKT_MODE(0)) u_dut_str (
    .clk (clk),
    .rst (rst),
    .bus (if_s)
  );

  typedef struct {
    int            ptr;
    bit            locked;
    int            lock_ch;
    bit            ov;
    logic [DW-1:0] od;
    bit            ol;
    int            oc;
  } model_t;

  typedef struct {
    logic          r;
    logic [N-1:0]  v;
    logic [N-1:0]  l;
    logic          rdy;
    logic [N-1:0]  exp_rdy;
    logic          exp_ov;
    logic          chk;
    logic [1:0]    exp_ch;
    logic [DW-1:0] exp_data;
    logic          exp_last;
  } vec_t;

  model_t        mdl [2];
  bit            pkt_of [2] = '{1'b1, 1'b0};
  string         tag [2] = '{"pkt", "str"};
  int            n_checks = 0;
  int            n_errors = 0;
  logic [N-1:0]  act_rdy [2];
  logic          act_ov [2];
  logic [DW-1:0] act_data [2];
  logic          act_last [2];
  logic [1:0]    act_ch [2];
  vec_t          tbl [22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset(input int j);
    mdl[j].ptr     = 0;
    mdl[j].locked  = 1'b0;
    mdl[j].lock_ch = 0;
    mdl[j].ov      = 1'b0;
    mdl[j].od      = '0;
    mdl[j].ol      = 1'b0;
    mdl[j].oc      = 0;
  endtask

  // Channel chosen this cycle, or -1: owner only while locked, else first valid from ptr upward.
  function automatic int model_pick(input int j);
    int c;
    if (mdl[j].locked) return tb_valid[mdl[j].lock_ch] ? mdl[j].lock_ch : -1;
    for (int i = 0; i < N; i++) begin
      c = (mdl[j].ptr + i) % N;
      if (tb_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check in_ready before the edge, advance the model, check outputs after it.
  task automatic step();
    int           g [2];
    logic [N-1:0] exp_rdy;
    #1;
    act_rdy[0] = if_p.in_ready;
    act_rdy[1] = if_s.in_ready;
    for (int j = 0; j < 2; j++) begin
      g[j] = model_pick(j);
      exp_rdy = '0;
      if (!rst && (!mdl[j].ov || tb_ready) && g[j] >= 0) exp_rdy[g[j]] = 1'b1;
      check($sformatf("%s in_ready", tag[j]), 64'(act_rdy[j]), 64'(exp_rdy));
    end
    @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      if (rst) begin
        model_reset(j);
      end else if ((!mdl[j].ov || tb_ready) && g[j] >= 0) begin
        mdl[j].ov = 1'b1;
        mdl[j].od = tb_data[g[j]*DW +: DW];
        mdl[j].ol = tb_last[g[j]];
        mdl[j].oc = g[j];
        if (pkt_of[j] && !mdl[j].locked && !tb_last[g[j]]) begin
          mdl[j].locked  = 1'b1;
          mdl[j].lock_ch = g[j];
        end else if (mdl[j].locked && tb_last[g[j]]) begin
          mdl[j].locked = 1'b0;
          mdl[j].ptr    = (g[j] + 1) % N;
        end else if (!mdl[j].locked) begin
          mdl[j].ptr = (g[j] + 1) % N;
        end
      end else if (mdl[j].ov && tb_ready) begin
        mdl[j].ov = 1'b0;
      end
    end
    @(negedge clk);
    act_ov[0] = if_p.out_valid;  act_data[0] = if_p.out_data;
    act_last[0] = if_p.out_last; act_ch[0] = if_p.out_ch;
    act_ov[1] = if_s.out_valid;  act_data[1] = if_s.out_data;
    act_last[1] = if_s.out_last; act_ch[1] = if_s.out_ch;
    for (int j = 0; j < 2; j++) begin
      check($sformatf("%s out_valid", tag[j]), 64'(act_ov[j]), 64'(mdl[j].ov));
      if (mdl[j].ov) begin
        check($sformatf("%s out_data", tag[j]), 64'(act_data[j]), 64'(mdl[j].od));
        check($sformatf("%s out_last", tag[j]), 64'(act_last[j]), 64'(mdl[j].ol));
        check($sformatf("%s out_ch", tag[j]), 64'(act_ch[j]), 64'(mdl[j].oc));
      end
    end
  endtask

  task automatic drive(input logic r, input logic [N-1:0] v, input logic [N-1:0] l, input logic rdy);
    rst      = r;
    tb_valid = v;
    tb_last  = l;
    tb_ready = rdy;
  endtask

  function automatic vec_t mk(input logic r, input logic [N-1:0] v, input logic [N-1:0] l,
                              input logic rdy, input logic [N-1:0] er, input logic eov,
                              input logic chk, input logic [1:0] ech, input logic [DW-1:0] ed,
                              input logic el);
    vec_t t;
    t.r = r; t.v = v; t.l = l; t.rdy = rdy; t.exp_rdy = er; t.exp_ov = eov;
    t.chk = chk; t.exp_ch = ech; t.exp_data = ed; t.exp_last = el;
    return t;
  endfunction

  initial begin
    int exp_str [4];
    logic [N*DW-1:0] base_data;

    base_data = {8'h43, 8'h32, 8'h21, 8'h10};
    model_reset(0);
    model_reset(1);
    tb_data = base_data;
    drive(1'b1, 4'h0, 4'h0, 1'b1);

    // Reset, fairness, sparse request, packet lock and bubble (packet-mode instance).
    tbl[0]  = mk(1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 8'h00, 1'b0);
    tbl[1]  = mk(1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 1'b1, 2'd0, 8'h10, 1'b1);
    tbl[2]  = mk(1'b0, 4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 1'b1, 2'd1, 8'h21, 1'b1);
    tbl[3]  = mk(1'b0, 4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 1'b1, 2'd2, 8'h32, 1'b1);
    tbl[4]  = mk(1'b0, 4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 1'b1, 2'd3, 8'h43, 1'b1);
    tbl[5]  = mk(1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 1'b1, 2'd0, 8'h10, 1'b1);
    tbl[6]  = mk(1'b0, 4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 1'b1, 2'd1, 8'h21, 1'b1);
    tbl[7]  = mk(1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 8'h00, 1'b0);
    tbl[8]  = mk(1'b0, 4'h4, 4'hF, 1'b1, 4'h4, 1'b1, 1'b1, 2'd2, 8'h32, 1'b1);
    tbl[9]  = mk(1'b0, 4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 1'b1, 2'd3, 8'h43, 1'b1);
    tbl[10] = mk(1'b0, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    tbl[11] = mk(1'b0, 4'h1, 4'hF, 1'b1, 4'h1, 1'b1, 1'b1, 2'd0, 8'h10, 1'b1);
    tbl[12] = mk(1'b0, 4'hB, 4'h9, 1'b1, 4'h2, 1'b1, 1'b1, 2'd1, 8'h21, 1'b0);
    tbl[13] = mk(1'b0, 4'hB, 4'h9, 1'b1, 4'h2, 1'b1, 1'b1, 2'd1, 8'h21, 1'b0);
    tbl[14] = mk(1'b0, 4'hB, 4'hB, 1'b1, 4'h2, 1'b1, 1'b1, 2'd1, 8'h21, 1'b1);
    tbl[15] = mk(1'b0, 4'hB, 4'hB, 1'b1, 4'h8, 1'b1, 1'b1, 2'd3, 8'h43, 1'b1);
    tbl[16] = mk(1'b0, 4'hB, 4'hB, 1'b1, 4'h1, 1'b1, 1'b1, 2'd0, 8'h10, 1'b1);
    tbl[17] = mk(1'b0, 4'hB, 4'h9, 1'b1, 4'h2, 1'b1, 1'b1, 2'd1, 8'h21, 1'b0);
    tbl[18] = mk(1'b0, 4'h9, 4'h9, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    tbl[19] = mk(1'b0, 4'hB, 4'h9, 1'b1, 4'h2, 1'b1, 1'b1, 2'd1, 8'h21, 1'b0);
    tbl[20] = mk(1'b0, 4'hB, 4'hB, 1'b1, 4'h2, 1'b1, 1'b1, 2'd1, 8'h21, 1'b1);
    tbl[21] = mk(1'b0, 4'hB, 4'hB, 1'b1, 4'h8, 1'b1, 1'b1, 2'd3, 8'h43, 1'b1);

    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].rdy);
      step();
      check($sformatf("tbl%0d in_ready", i), 64'(act_rdy[0]), 64'(tbl[i].exp_rdy));
      check($sformatf("tbl%0d out_valid", i), 64'(act_ov[0]), 64'(tbl[i].exp_ov));
      if (tbl[i].chk) begin
        check($sformatf("tbl%0d out_ch", i), 64'(act_ch[0]), 64'(tbl[i].exp_ch));
        check($sformatf("tbl%0d out_data", i), 64'(act_data[0]), 64'(tbl[i].exp_data));
        check($sformatf("tbl%0d out_last", i), 64'(act_last[0]), 64'(tbl[i].exp_last));
      end
    end

    // Backpressure: fill with ch 0, hold 5 cycles, then drain and reload in one cycle.
    drive(1'b0, 4'hF, 4'hF, 1'b1);
    step();
    check("bp fill ch", 64'(act_ch[0]), 64'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'hF, 4'hF, 1'b0);
      step();
      check("bp hold in_ready", 64'(act_rdy[0]), 64'h0);
      check("bp hold valid", 64'(act_ov[0]), 64'd1);
      check("bp hold ch", 64'(act_ch[0]), 64'd0);
      check("bp hold data", 64'(act_data[0]), 64'h10);
    end
    drive(1'b0, 4'hF, 4'hF, 1'b1);
    step();
    check("bp release in_ready", 64'(act_rdy[0]), 64'h2);
    check("bp release valid", 64'(act_ov[0]), 64'd1);
    check("bp release ch", 64'(act_ch[0]), 64'd1);
    check("bp release data", 64'(act_data[0]), 64'h21);

    // Reset while locked on ch 1: lock and output beat are dropped, ch 0 wins next.
    drive(1'b1, 4'h0, 4'h0, 1'b1);
    step();
    drive(1'b0, 4'h2, 4'h0, 1'b1);
    step();
    check("rstlock first ch", 64'(act_ch[0]), 64'd1);
    drive(1'b1, 4'hF, 4'hF, 1'b1);
    step();
    check("rstlock in_ready", 64'(act_rdy[0]), 64'h0);
    check("rstlock valid", 64'(act_ov[0]), 64'd0);
    drive(1'b0, 4'hF, 4'hF, 1'b1);
    step();
    check("rstlock regrant rdy", 64'(act_rdy[0]), 64'h1);
    check("rstlock regrant ch", 64'(act_ch[0]), 64'd0);

    // Two multi-beat streams: streaming mode alternates, packet mode stays on ch 0.
    drive(1'b1, 4'h0, 4'h0, 1'b1);
    step();
    exp_str = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'h3, 4'h0, 1'b1);
      step();
      check($sformatf("str beat%0d ch", i), 64'(act_ch[1]), 64'(exp_str[i]));
      check($sformatf("pkt beat%0d ch", i), 64'(act_ch[0]), 64'd0);
    end

    // Randomised traffic, checked against the reference model every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      tb_valid = N'($urandom);
      tb_last  = N'($urandom);
      tb_data  = {$urandom};
      tb_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_mux.md
# rr_arbiter_mux

Parametrised round-robin arbiter and multiplexer, successor to the fixed two-input time-slot arbiter. Merges `NUM_CH` valid/ready source streams into one registered output stream. Grants only channels with pending data instead of cycling blindly through fixed slots. In packet mode, holds the grant until the packet ends; the per-beat `last` flag replaces the old reset bit carried alongside the data byte.

## Interface
Parameters:
- `NUM_CH`, 4, number of input channels (2..16)
- `DATA_W`, 8, payload width per beat
- `PKT_MODE`, 1, 1 = hold grant until the beat with `in_last` is accepted; 0 = re-arbitrate every beat

Ports:
- `clk` in 1: single clock; all logic on the rising edge
- `rst` in 1: synchronous, active-high reset
- `in_valid` in `NUM_CH`: per-channel beat available
- `in_data` in `NUM_CH*DATA_W`: channel k occupies bits `[k*DATA_W +: DATA_W]`
- `in_last` in `NUM_CH`: per-channel end-of-packet flag
- `in_ready` out `NUM_CH`: per-channel beat accepted this cycle when `in_valid[k] & in_ready[k]`
- `out_valid` out 1: output register holds a beat
- `out_data` out `DATA_W`: registered payload
- `out_last` out 1: registered end-of-packet flag
- `out_ch` out `CH_W` = `$clog2(NUM_CH)`: source channel of the current output beat
- `out_ready` in 1: downstream accepts when `out_valid & out_ready`

## Operation
- Round-robin pointer `ptr` marks the highest-priority channel.
  - Combinational pick = first k with `in_valid[k]`, scanning from `ptr` upward and wrapping modulo `NUM_CH`.
- `load = !out_valid | out_ready`, i.e. the output register is free this cycle.
- `in_ready[k] = load & (k == pick) & any_valid`; at most one bit set. `in_ready` may depend on `in_valid`; `in_valid` must not depend on `in_ready`.
- On accept from channel g:
  - register `in_data[g]`, `in_last[g]` and g into the output
  - set `out_valid = 1`
  - `ptr <= (g+1) mod NUM_CH`, except while locked
- If `out_ready & out_valid` and no accept occurs, `out_valid <= 0`.
- Packet mode (`PKT_MODE=1`) state machine:
  - IDLE -> LOCKED when an accepted beat has `in_last=0`; `lock_ch <= g`.
  - In LOCKED, pick is forced to `lock_ch`. Other channels stall even if valid.
    - If `in_valid[lock_ch]=0`, no grant is given that cycle. Bubbles are allowed and the grant does not move.
  - LOCKED -> IDLE when the accepted beat from `lock_ch` has `in_last=1`. Pointer then advances to `lock_ch+1`.
  - Single-beat packet (`in_last=1` on the first beat) stays in IDLE.
- With `PKT_MODE=0`, the state stays IDLE and `in_last` is passed through only.
- No valid inputs: no accept, `ptr` unchanged.
- Reset mid-packet drops the lock and the output beat. No recovery of partial packets is attempted.

## Timing
- Latency 1 cycle: a beat accepted at edge n is visible on the outputs after edge n.
- Full throughput: one beat per cycle sustained while `out_ready=1`.
- Simultaneous output consume and input accept in the same cycle: the register is overwritten, `out_valid` stays 1.
- Outputs are stable while `out_valid & !out_ready` (backpressure hold).
- Reset values, applied at the first rising edge with `rst=1`:
  - `out_valid=0`, `out_data=0`, `out_last=0`, `out_ch=0`
  - `ptr=0`, state IDLE, `lock_ch=0`
  - `in_ready` all 0 while `rst=1`

## Structure
- Package `arb_pkg`:
  - `arb_state_e` {ARB_IDLE, ARB_LOCKED}
  - function `ch_w(n)` returning `$clog2(n)` with minimum 1
- Sub-module `rr_priority_pick`:
  - parameter `NUM_CH`
  - inputs `req`, `ptr`; outputs `gnt_idx`, `gnt_any`
  - purely combinational rotate / find-first / rotate-back
- Top level holds the output register, pointer, lock FSM and data mux.

## Test plan
- Reset mid-packet: `rst` high for 1 cycle while LOCKED on ch 1 -> next cycle `out_valid=0`, state IDLE, `ptr=0`; ch 0 wins the first grant after reset.
- Fairness: all four channels valid continuously with `in_last=1`, `out_ready=1` -> `out_ch` sequence 0,1,2,3,0,1, one beat per cycle, `out_data` matching each channel's payload (e.g. 0x10,0x21,0x32,0x43).
- Sparse request: only ch 2 valid with `ptr=0` -> ch 2 granted immediately, no idle slots; `ptr` becomes 3.
- Packet lock: ch 1 sends 3 beats (last on the 3rd) while ch 0 and ch 3 are valid -> `out_ch`=1,1,1,3,0.
  - Repeat with a 1-cycle bubble on ch 1 mid-packet -> no other channel is granted during the bubble.
- Backpressure: `out_ready=0` for 5 cycles with the output full -> `out_data`/`out_ch` stable, all `in_ready=0`; on release, one beat drains and the next loads in the same cycle.
- `PKT_MODE=0`: ch 0 and ch 1 both streaming multi-beat packets -> grants alternate 0,1,0,1 regardless of `in_last`.
